// File: rtl/cla_multiword_seq.sv
// Multi-word add/subtract sequencer: streams WORDS 16-bit slices through one
// external combinational adder, LSW first, chaining the carry between words.
module cla_multiword_seq #(
    parameter int WORDS = 4,
    parameter int IDXW  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  sub,
    input  logic [16*WORDS-1:0]   op_a,
    input  logic [16*WORDS-1:0]   op_b,
    output logic                  busy,
    output logic                  done,
    output logic [16*WORDS-1:0]   result,
    output logic                  carry_out,
    output logic                  overflow,
    output logic [15:0]           add_a,
    output logic [15:0]           add_b,
    output logic                  add_cin,
    input  logic [15:0]           add_s,
    input  logic                  add_cout
);

    localparam int W = 16 * WORDS;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]      state_q,  state_d;
    logic [IDXW-1:0] idx_q,    idx_d;
    logic            carry_q,  carry_d;
    logic            sub_q,    sub_d;
    logic [W-1:0]    a_q,      a_d;
    logic [W-1:0]    b_q,      b_d;
    logic [W-1:0]    result_q, result_d;
    logic            cout_q,   cout_d;
    logic            ovf_q,    ovf_d;

    logic [15:0]     word_a;
    logic [15:0]     word_b;

    // Constant-select mux keeps every slice in range regardless of idx width.
    always_comb begin
        word_a = '0;
        word_b = '0;
        for (int i = 0; i < WORDS; i++) begin
            if (idx_q == IDXW'(i)) begin
                word_a = a_q[16*i +: 16];
                word_b = b_q[16*i +: 16];
            end
        end
    end

    assign add_a   = (state_q == S_RUN) ? word_a : 16'd0;
    assign add_b   = (state_q == S_RUN) ? (word_b ^ {16{sub_q}}) : 16'd0;
    assign add_cin = (state_q == S_RUN) & carry_q;

    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign result    = result_q;
    assign carry_out = cout_q;
    assign overflow  = ovf_q;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        sub_d    = sub_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = op_a;
                    b_d     = op_b;
                    sub_d   = sub;
                    idx_d   = '0;
                    carry_d = sub;  // +1 of the two's-complement negate
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                for (int i = 0; i < WORDS; i++) begin
                    if (idx_q == IDXW'(i)) result_d[16*i +: 16] = add_s;
                end
                carry_d = add_cout;
                if (idx_q == IDXW'(WORDS - 1)) begin
                    cout_d  = add_cout;
                    ovf_d   = (add_a[15] == add_b[15]) && (add_s[15] != add_a[15]);
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            sub_q    <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            sub_q    <= sub_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end

endmodule

// File: tb/tb_cla_multiword_seq.sv
// Randomized and directed bench for cla_multiword_seq against an arithmetic
// reference model; a behavioural 16-bit adder serves as the external slice.
module tb_cla_multiword_seq;

    localparam int WORDS = 4;
    localparam int IDXW  = 4;
    localparam int W     = 16 * WORDS;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic           sub;
    logic [W-1:0]   op_a;
    logic [W-1:0]   op_b;
    logic           busy;
    logic           done;
    logic [W-1:0]   result;
    logic           carry_out;
    logic           overflow;
    logic [15:0]    add_a;
    logic [15:0]    add_b;
    logic           add_cin;
    logic [15:0]    add_s;
    logic           add_cout;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {16'd0, add_cin};

    cla_multiword_seq #(.WORDS(WORDS), .IDXW(IDXW)) dut (
        .clk(clk), .rst(rst), .start(start), .sub(sub),
        .op_a(op_a), .op_b(op_b),
        .busy(busy), .done(done), .result(result),
        .carry_out(carry_out), .overflow(overflow),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_s(add_s), .add_cout(add_cout)
    );

    // Reference: plain W-bit arithmetic; cin[k] is the carry out of the low k words.
    function automatic void ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic s, output logic [W-1:0] r,
                                   output logic c, output logic v,
                                   output logic [WORDS-1:0] cin);
        logic [W:0]   full;
        logic [W:0]   m;
        logic [W:0]   t;
        logic [W-1:0] be;
        be = s ? ~b : b;
        if (s) begin
            r = a - b;
            c = (a >= b);
            v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
        end else begin
            full = {1'b0, a} + {1'b0, b};
            r = full[W-1:0];
            c = full[W];
            v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
        end
        for (int k = 0; k < WORDS; k++) begin
            m = ({{W{1'b0}}, 1'b1} << (16 * k)) - 1'b1;
            t = ({1'b0, a} & m) + ({1'b0, be} & m) + {{W{1'b0}}, s};
            cin[k] = t[16 * k];
        end
    endfunction

    // Drives one request from IDLE and observes the whole handshake.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                          output int done_n, output int busy_n, output int n_dones,
                          output logic [WORDS-1:0] cins, output logic tmo);
        @(negedge clk);
        op_a = a; op_b = b; sub = s; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        op_a = {$urandom, $urandom};
        op_b = {$urandom, $urandom};
        sub  = ~s;
        done_n = -1; busy_n = 0; n_dones = 0; cins = '0; tmo = 1'b1;
        for (int n = 0; n < 20; n++) begin
            if (n > 0) begin
                @(posedge clk);
                #1;
            end
            if (busy) busy_n++;
            if (n < WORDS) cins[n] = add_cin;
            if (done) begin
                n_dones++;
                if (done_n < 0) done_n = n;
            end
            if (!busy && n > 0) begin
                tmo = 1'b0;
                break;
            end
        end
    endtask

    task automatic check_op(input string name, input logic [W-1:0] a,
                            input logic [W-1:0] b, input logic s);
        logic [W-1:0]     er;
        logic             ec, ev;
        logic [WORDS-1:0] ecin, cins;
        int               dn, bn, nd;
        logic             tmo;
        ref_op(a, b, s, er, ec, ev, ecin);
        run_op(a, b, s, dn, bn, nd, cins, tmo);
        checks++;
        if (tmo !== 1'b0) begin
            errors++;
            $display("FAIL %s timeout: busy never dropped", name);
        end
        checks++;
        if (result !== er) begin
            errors++;
            $display("FAIL %s result: got %h expected %h", name, result, er);
        end
        checks++;
        if (carry_out !== ec) begin
            errors++;
            $display("FAIL %s carry_out: got %b expected %b", name, carry_out, ec);
        end
        checks++;
        if (overflow !== ev) begin
            errors++;
            $display("FAIL %s overflow: got %b expected %b", name, overflow, ev);
        end
        checks++;
        if (dn != WORDS || nd != 1) begin
            errors++;
            $display("FAIL %s done timing: at %0d count %0d expected at %0d count 1",
                     name, dn, nd, WORDS);
        end
        checks++;
        if (bn != WORDS + 1) begin
            errors++;
            $display("FAIL %s busy cycles: got %0d expected %0d", name, bn, WORDS + 1);
        end
        checks++;
        if (cins !== ecin) begin
            errors++;
            $display("FAIL %s add_cin per word: got %b expected %b", name, cins, ecin);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; sub = 1'b0; op_a = '0; op_b = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, carry_out, overflow} !== 4'b0000) begin
            errors++;
            $display("FAIL reset flags: busy/done/cout/ovf got %b expected 0000",
                     {busy, done, carry_out, overflow});
        end
        checks++;
        if (result !== '0) begin
            errors++;
            $display("FAIL reset result: got %h expected 0", result);
        end
        checks++;
        if ({add_a, add_b, add_cin} !== 33'd0) begin
            errors++;
            $display("FAIL reset adder drive: got %h expected 0", {add_a, add_b, add_cin});
        end
        // start coincident with reset must be dropped
        @(negedge clk);
        start = 1'b1; op_a = 64'h1234; op_b = 64'h1;
        @(posedge clk);
        #1;
        rst = 1'b0; start = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL start_with_rst: busy got %b expected 0", busy);
        end
    endtask

    task automatic test_directed();
        logic [W-1:0] da [6];
        logic [W-1:0] db [6];
        logic         ds [6];
        da[0] = 64'hFFFF_FFFF_FFFF_FFFF; db[0] = 64'h1; ds[0] = 1'b0;
        da[1] = 64'h0;                   db[1] = 64'h1; ds[1] = 1'b1;
        da[2] = 64'h5;                   db[2] = 64'h5; ds[2] = 1'b1;
        da[3] = 64'h7FFF_FFFF_FFFF_FFFF; db[3] = 64'h1; ds[3] = 1'b0;
        da[4] = 64'h8000_0000_0000_0000; db[4] = 64'h1; ds[4] = 1'b1;
        da[5] = 64'h0000_FFFF_0000_FFFF; db[5] = 64'h0000_0001_0000_0001; ds[5] = 1'b0;
        for (int i = 0; i < 6; i++) check_op($sformatf("directed%0d", i), da[i], db[i], ds[i]);
        // result holds through IDLE
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (result !== 64'h0001_0000_0001_0000) begin
            errors++;
            $display("FAIL hold_in_idle: result got %h expected 0001000000010000", result);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] a, b;
        logic         s;
        for (int i = 0; i < 25; i++) begin
            a = {$urandom, $urandom};
            b = (i % 7 == 3) ? a : {$urandom, $urandom};
            s = 1'($urandom_range(0, 1));
            check_op($sformatf("random%0d", i), a, b, s);
        end
    endtask

    task automatic test_start_held();
        logic [W-1:0]     a1, b1, a2, b2, r1, r2;
        logic             s1, s2, c1, c2, v1, v2;
        logic [WORDS-1:0] ci;
        logic [15:0]      dmask;
        a1 = {$urandom, $urandom}; b1 = {$urandom, $urandom}; s1 = 1'b0;
        a2 = {$urandom, $urandom}; b2 = {$urandom, $urandom}; s2 = 1'b1;
        ref_op(a1, b1, s1, r1, c1, v1, ci);
        ref_op(a2, b2, s2, r2, c2, v2, ci);
        dmask = '0;
        @(negedge clk);
        op_a = a1; op_b = b1; sub = s1; start = 1'b1;
        @(posedge clk);
        #1;
        for (int n = 0; n < 14; n++) begin
            if (n > 0) begin
                @(posedge clk);
                #1;
            end
            if (n == 2) begin
                op_a = a2; op_b = b2; sub = s2;
            end
            if (n == 2 * WORDS) begin
                op_a = {$urandom, $urandom}; op_b = {$urandom, $urandom}; sub = 1'b0;
            end
            if (done) dmask[n] = 1'b1;
            if (n == WORDS) begin
                checks++;
                if ({result, carry_out, overflow} !== {r1, c1, v1}) begin
                    errors++;
                    $display("FAIL start_held op1: got %h/%b/%b expected %h/%b/%b",
                             result, carry_out, overflow, r1, c1, v1);
                end
            end
            if (n == 2 * WORDS + 2) begin
                start = 1'b0;
                checks++;
                if ({result, carry_out, overflow} !== {r2, c2, v2}) begin
                    errors++;
                    $display("FAIL start_held op2: got %h/%b/%b expected %h/%b/%b",
                             result, carry_out, overflow, r2, c2, v2);
                end
            end
        end
        checks++;
        if (dmask !== 16'h0410) begin
            errors++;
            $display("FAIL start_held done cycles: got mask %h expected 0410", dmask);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL start_held idle after: busy got %b expected 0", busy);
        end
    endtask

    task automatic test_reset_mid_run();
        int nd;
        @(negedge clk);
        op_a = 64'h1111_2222_3333_4444; op_b = 64'h0101_0101_0101_0101; sub = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++;
            $display("FAIL reset_mid_run flags: busy/done got %b expected 00", {busy, done});
        end
        checks++;
        if ({result, carry_out, overflow} !== {{W{1'b0}}, 2'b00}) begin
            errors++;
            $display("FAIL reset_mid_run outputs: got %h/%b/%b expected 0/0/0",
                     result, carry_out, overflow);
        end
        nd = 0;
        for (int n = 0; n < 8; n++) begin
            @(posedge clk);
            #1;
            if (done) nd++;
        end
        checks++;
        if (nd != 0) begin
            errors++;
            $display("FAIL reset_mid_run stray done: got %0d expected 0", nd);
        end
        check_op("after_reset", 64'h1111_2222_3333_4444, 64'h0101_0101_0101_0101, 1'b1);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_start_held();
        test_reset_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
